wptr_full_level: RTL and testbench

WPTR_FULL_LEVEL -- requirements
Module: wptr_full_level

---
 rtl/wptr_full_level.sv | 92 +++++++++
 tb/tb_wptr_full_level.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/wptr_full_level.sv
// Write-side FIFO pointer with full, almost-full, fill level and sticky overflow.
// Latency: wen/waddr combinational from winc; wptr and all flags registered, one wclk after the write.
// Backpressure: writes are refused while wfull is set; a refused write raises woverflow.
//
// Ports:
//   wclk, wrst     write clock, synchronous active-high reset
//   winc           write request
//   wq2_rptr       Gray read pointer already synchronised into wclk
//   afull_thresh   almost-full threshold in entries (binary)
//   wovf_clr       clears the sticky overflow flag
//   wen, waddr     memory write enable and address
//   wptr           registered Gray write pointer, for the read-domain synchroniser
//   wfull, walmost_full, wlevel, woverflow   registered status
module wptr_full_level #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  input  logic [ADDR_WIDTH:0]   afull_thresh,
  input  logic                  wovf_clr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  localparam int A = ADDR_WIDTH;

  logic [A:0] wbin;
  logic [A:0] wbinnext;
  logic [A:0] wgraynext;
  logic [A:0] rbin;
  logic [A:0] level_next;
  logic [A:0] full_ptr;
  logic       accept;
  logic       full_next;
  logic       afull_next;

  // Only the registered wfull gates the write, so wq2_rptr never reaches wen.
  assign accept    = winc & ~wfull;
  assign wen       = accept;
  assign waddr     = wbin[A-1:0];
  assign wbinnext  = wbin + {{A{1'b0}}, accept};
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin    = '0;
    rbin[A] = wq2_rptr[A];
    for (int i = A - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ wq2_rptr[i];
    end
  end

  // Modulo subtraction keeps the level correct across pointer wrap.
  assign level_next = wbinnext - rbin;

  // Full when the write pointer is one lap ahead of the read pointer:
  // in Gray code that means the top two bits inverted, the rest equal.
  assign full_ptr   = {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]};
  assign full_next  = (wgraynext == full_ptr);
  assign afull_next = (level_next >= afull_thresh);

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wlevel       <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wlevel       <= level_next;
      wfull        <= full_next;
      walmost_full <= afull_next;
      // A refused write outranks a simultaneous clear.
      if (winc && wfull) begin
        woverflow <= 1'b1;
      end else if (wovf_clr) begin
        woverflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wptr_full_level.sv
module tb_wptr_full_level;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       winc;
  logic [2:0] wq2_rptr;
  logic [2:0] afull_thresh;
  logic       wovf_clr;
  logic       wen;
  logic [1:0] waddr;
  logic [2:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [2:0] wlevel;
  logic       woverflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 wclk = ~wclk;

  wptr_full_level #(.ADDR_WIDTH(2)) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .afull_thresh (afull_thresh),
    .wovf_clr     (wovf_clr),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [2:0] gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [3:0] w;
  logic [3:0] rb;

  initial begin
    wrst = 1'b1; winc = 1'b0; wq2_rptr = 3'b000; afull_thresh = 3'd3; wovf_clr = 1'b0;
    tick(); tick();
    chk("rst_level", wlevel, 0);
    chk("rst_full", wfull, 0);
    chk("rst_afull", walmost_full, 0);
    chk("rst_wptr", wptr, 0);
    chk("rst_ovf", woverflow, 0);
    chk("rst_waddr", waddr, 0);

    // Fill four entries with the reader idle.
    wrst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      winc = 1'b1; #1;
      chk("fill_wen", wen, 1);
      chk("fill_waddr", waddr, i - 1);
      tick();
      chk("fill_level", wlevel, i);
      chk("fill_afull", walmost_full, (i >= 3) ? 1 : 0);
      chk("fill_full", wfull, (i == 4) ? 1 : 0);
    end
    chk("fill_wptr", wptr, 3'b110);

    // Writes while full are refused and flagged.
    winc = 1'b1; #1;
    chk("ovf_wen", wen, 0);
    tick(); tick();
    chk("ovf_wptr", wptr, 3'b110);
    chk("ovf_level", wlevel, 4);
    chk("ovf_set", woverflow, 1);
    winc = 1'b0; wovf_clr = 1'b1;
    tick();
    chk("ovf_clr", woverflow, 0);
    wovf_clr = 1'b0;

    // Threshold above depth never asserts almost-full.
    afull_thresh = 3'd5;
    tick();
    chk("thr_hi_afull", walmost_full, 0);
    afull_thresh = 3'd3;

    // Reader advances by one: full drops a cycle later.
    wq2_rptr = 3'b001;
    tick();
    chk("rd_full", wfull, 0);
    chk("rd_level", wlevel, 3);
    winc = 1'b1; #1;
    chk("rd_wen", wen, 1);
    chk("rd_waddr", waddr, 0);
    tick();
    chk("rd_refull", wfull, 1);
    chk("rd_relevel", wlevel, 4);
    winc = 1'b0;

    // Steady level of 2 across a pointer wrap.
    wrst = 1'b1; wq2_rptr = 3'b000; tick(); wrst = 1'b0;
    afull_thresh = 3'd0;
    tick();
    chk("thr0_afull", walmost_full, 1);
    afull_thresh = 3'd3;
    winc = 1'b1; tick(); tick();
    chk("pre_level", wlevel, 2);
    w = 4'd2; rb = 4'd0;
    for (int k = 0; k < 10; k++) begin
      rb = w - 4'd1;
      wq2_rptr = gray(rb[2:0]);
      winc = 1'b1; #1;
      chk("wrap_waddr", waddr, w[1:0]);
      tick();
      w = w + 4'd1;
      chk("wrap_level", wlevel, 2);
      chk("wrap_full", wfull, 0);
      chk("wrap_wptr", wptr, gray(w[2:0]));
    end

    // Fill to full, then set and clear together: set wins.
    tick(); tick();
    chk("fill2_full", wfull, 1);
    wovf_clr = 1'b1; winc = 1'b1;
    tick();
    chk("ovf_setwins", woverflow, 1);
    winc = 1'b0;
    tick();
    chk("ovf_clr2", woverflow, 0);
    wovf_clr = 1'b0;

    // Reset in the middle of traffic.
    wrst = 1'b1; wq2_rptr = 3'b000; tick(); wrst = 1'b0;
    winc = 1'b1; tick(); tick(); tick();
    chk("mid_level", wlevel, 3);
    wrst = 1'b1; #1;
    chk("mid_wen", wen, 1);
    tick();
    chk("mid_rst_level", wlevel, 0);
    chk("mid_rst_wptr", wptr, 0);
    chk("mid_rst_afull", walmost_full, 0);
    chk("mid_rst_full", wfull, 0);
    chk("mid_rst_waddr", waddr, 0);
    wrst = 1'b0; #1;
    chk("post_wen", wen, 1);
    chk("post_waddr", waddr, 0);
    tick();
    chk("post_level", wlevel, 1);
    winc = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
